mem_arb: RTL and testbench

Single-port memory arbiter and transaction sequencer between the instruction-fetch unit and the load/store unit. Both requesters share one downstream memory port, with at most one transaction outstanding. The LSU has fixed priority over the IFU, and a bounded-streak rule guarantees fetch progress. The block sits between `ifu`/`lsu` and the memory model or bus bridge, and lets the core move from combinational DPI memory to a handshaked, multi-cycle memory.

---
 rtl/mem_arb_pkg.sv | 10 +
 rtl/mem_arb.sv | 140 ++++++++++++++
 tb/tb_mem_arb.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the single-port memory arbiter.
package mem_arb_pkg;

    localparam int unsigned CPU_WIDTH = 64;
    localparam int unsigned STREAK_W  = 4;

    typedef enum logic [1:0] {IDLE, REQ, RSP} mem_arb_state_e;
    typedef enum logic {OWN_IFU, OWN_LSU} mem_arb_own_e;

endpackage

// File: rtl/mem_arb.sv
// Arbitrates IFU and LSU onto one handshaked memory port, one transaction in flight.
// LSU wins ties until STARVE_MAX consecutive wins leave the IFU waiting.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = CPU_WIDTH,
    parameter int unsigned DATA_W     = CPU_WIDTH,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_ifu_req_valid,
    output logic                o_ifu_req_ready,
    input  logic [ADDR_W-1:0]   i_ifu_addr,
    output logic                o_ifu_rsp_valid,
    output logic [DATA_W-1:0]   o_ifu_rdata,
    input  logic                i_lsu_req_valid,
    output logic                o_lsu_req_ready,
    input  logic [ADDR_W-1:0]   i_lsu_addr,
    input  logic                i_lsu_wen,
    input  logic [DATA_W-1:0]   i_lsu_wdata,
    input  logic [DATA_W/8-1:0] i_lsu_wmask,
    output logic                o_lsu_rsp_valid,
    output logic [DATA_W-1:0]   o_lsu_rdata,
    output logic                o_mem_req_valid,
    input  logic                i_mem_req_ready,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic                o_mem_wen,
    output logic [DATA_W-1:0]   o_mem_wdata,
    output logic [DATA_W/8-1:0] o_mem_wmask,
    input  logic                i_mem_rsp_valid,
    input  logic [DATA_W-1:0]   i_mem_rdata,
    output logic                o_busy
);

    localparam logic [STREAK_W-1:0] StarveMax = STREAK_W'(STARVE_MAX);

    mem_arb_state_e        state_q, state_d;
    mem_arb_own_e          own_q, own_d;
    logic [STREAK_W-1:0]   streak_q, streak_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic                  wen_q, wen_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W/8-1:0]   wmask_q, wmask_d;

    logic idle;
    logic ifu_starved;
    logic grant_lsu;
    logic grant_ifu;
    logic rsp_fire;

    // Readies are suppressed while reset is asserted so every output reads 0.
    assign idle        = (state_q == IDLE) && !i_rst;
    assign ifu_starved = i_ifu_req_valid && (streak_q == StarveMax);
    assign grant_lsu   = idle && i_lsu_req_valid && !ifu_starved;
    assign grant_ifu   = idle && i_ifu_req_valid && !grant_lsu;
    assign rsp_fire    = (state_q == RSP) && i_mem_rsp_valid && !i_rst;

    always_comb begin
        state_d  = state_q;
        own_d    = own_q;
        streak_d = streak_q;
        addr_d   = addr_q;
        wen_d    = wen_q;
        wdata_d  = wdata_q;
        wmask_d  = wmask_q;
        unique case (state_q)
            IDLE: begin
                if (grant_lsu) begin
                    state_d = REQ;
                    own_d   = OWN_LSU;
                    addr_d  = i_lsu_addr;
                    wen_d   = i_lsu_wen;
                    wdata_d = i_lsu_wdata;
                    wmask_d = i_lsu_wmask;
                    if (!i_ifu_req_valid) begin
                        streak_d = '0;
                    end else if (streak_q != StarveMax) begin
                        streak_d = streak_q + 1'b1;
                    end
                end else if (grant_ifu) begin
                    state_d  = REQ;
                    own_d    = OWN_IFU;
                    addr_d   = i_ifu_addr;
                    wen_d    = 1'b0;
                    wdata_d  = '0;
                    wmask_d  = '0;
                    streak_d = '0;
                end
            end
            REQ: begin
                if (i_mem_req_ready) begin
                    state_d = RSP;
                end
            end
            RSP: begin
                if (i_mem_rsp_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            own_q    <= OWN_IFU;
            streak_q <= '0;
            addr_q   <= '0;
            wen_q    <= 1'b0;
            wdata_q  <= '0;
            wmask_q  <= '0;
        end else begin
            state_q  <= state_d;
            own_q    <= own_d;
            streak_q <= streak_d;
            addr_q   <= addr_d;
            wen_q    <= wen_d;
            wdata_q  <= wdata_d;
            wmask_q  <= wmask_d;
        end
    end

    assign o_ifu_req_ready = grant_ifu;
    assign o_lsu_req_ready = grant_lsu;

    assign o_ifu_rsp_valid = rsp_fire && (own_q == OWN_IFU);
    assign o_lsu_rsp_valid = rsp_fire && (own_q == OWN_LSU);
    assign o_ifu_rdata     = o_ifu_rsp_valid ? i_mem_rdata : '0;
    assign o_lsu_rdata     = (o_lsu_rsp_valid && !wen_q) ? i_mem_rdata : '0;

    assign o_mem_req_valid = (state_q == REQ);
    assign o_mem_addr      = addr_q;
    assign o_mem_wen       = wen_q;
    assign o_mem_wdata     = wdata_q;
    assign o_mem_wmask     = wmask_q;
    assign o_busy          = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arb.sv
// Directed and randomised checks of mem_arb against a cycle-based memory model and scoreboard.
module tb_mem_arb;

    localparam int unsigned AW   = 64;
    localparam int unsigned DW   = 64;
    localparam int unsigned MW   = DW / 8;
    localparam int          NREQ = 1000;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_ifu_req_valid = 1'b0;
    logic          o_ifu_req_ready;
    logic [AW-1:0] i_ifu_addr = '0;
    logic          o_ifu_rsp_valid;
    logic [DW-1:0] o_ifu_rdata;
    logic          i_lsu_req_valid = 1'b0;
    logic          o_lsu_req_ready;
    logic [AW-1:0] i_lsu_addr = '0;
    logic          i_lsu_wen = 1'b0;
    logic [DW-1:0] i_lsu_wdata = '0;
    logic [MW-1:0] i_lsu_wmask = '0;
    logic          o_lsu_rsp_valid;
    logic [DW-1:0] o_lsu_rdata;
    logic          o_mem_req_valid;
    logic          i_mem_req_ready = 1'b0;
    logic [AW-1:0] o_mem_addr;
    logic          o_mem_wen;
    logic [DW-1:0] o_mem_wdata;
    logic [MW-1:0] o_mem_wmask;
    logic          i_mem_rsp_valid = 1'b0;
    logic [DW-1:0] i_mem_rdata = '0;
    logic          o_busy;

    always #5 i_clk = ~i_clk;

    mem_arb #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .STARVE_MAX(4)
    ) u_dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_ifu_req_valid(i_ifu_req_valid),
        .o_ifu_req_ready(o_ifu_req_ready),
        .i_ifu_addr     (i_ifu_addr),
        .o_ifu_rsp_valid(o_ifu_rsp_valid),
        .o_ifu_rdata    (o_ifu_rdata),
        .i_lsu_req_valid(i_lsu_req_valid),
        .o_lsu_req_ready(o_lsu_req_ready),
        .i_lsu_addr     (i_lsu_addr),
        .i_lsu_wen      (i_lsu_wen),
        .i_lsu_wdata    (i_lsu_wdata),
        .i_lsu_wmask    (i_lsu_wmask),
        .o_lsu_rsp_valid(o_lsu_rsp_valid),
        .o_lsu_rdata    (o_lsu_rdata),
        .o_mem_req_valid(o_mem_req_valid),
        .i_mem_req_ready(i_mem_req_ready),
        .o_mem_addr     (o_mem_addr),
        .o_mem_wen      (o_mem_wen),
        .o_mem_wdata    (o_mem_wdata),
        .o_mem_wmask    (o_mem_wmask),
        .i_mem_rsp_valid(i_mem_rsp_valid),
        .i_mem_rdata    (i_mem_rdata),
        .o_busy         (o_busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pulse counters and handshake invariants, sampled mid-cycle.
    int   ifu_pulses = 0;
    int   lsu_pulses = 0;
    logic both_ready_seen = 1'b0;
    logic ready_busy_seen = 1'b0;

    always @(negedge i_clk) begin
        if (o_ifu_rsp_valid) ifu_pulses++;
        if (o_lsu_rsp_valid) lsu_pulses++;
        if (o_ifu_req_ready && o_lsu_req_ready) both_ready_seen = 1'b1;
        if ((o_ifu_req_ready || o_lsu_req_ready) && o_busy) ready_busy_seen = 1'b1;
    end

    function automatic logic [63:0] mem_val(input logic [63:0] a);
        return a ^ 64'hA5A5_0000_0000_5A5A;
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Cycle-based memory: ready after 0..rdly_max cycles, response 1..sdly_max+1 cycles later.
    int            m_phase = 0;
    int            m_cnt = 0;
    logic [63:0]   m_addr = '0;
    int unsigned   rdly_max = 0;
    int unsigned   sdly_max = 0;

    task automatic mem_cycle();
        i_mem_req_ready = 1'b0;
        i_mem_rsp_valid = 1'b0;
        i_mem_rdata     = '0;
        if (m_phase == 2) begin
            if (m_cnt == 0) begin
                i_mem_rsp_valid = 1'b1;
                i_mem_rdata     = mem_val(m_addr);
                m_phase         = 0;
            end else begin
                m_cnt--;
            end
        end else begin
            if (m_phase == 0 && o_mem_req_valid) begin
                m_phase = 1;
                m_cnt   = int'($urandom_range(rdly_max, 0));
            end
            if (m_phase == 1) begin
                if (m_cnt == 0) begin
                    i_mem_req_ready = 1'b1;
                    m_addr          = o_mem_addr;
                    m_phase         = 2;
                    m_cnt           = int'($urandom_range(sdly_max, 0));
                end else begin
                    m_cnt--;
                end
            end
        end
    endtask

    initial begin
        int          snap_i;
        int          snap_l;
        logic [5:0]  order;
        logic [5:0]  exp_order;
        int          ng;
        int          issued;
        int          accepted;
        int          responded;
        int          cyc;
        logic        exp_pending;
        logic        exp_own;
        logic [63:0] exp_data;
        logic        ifu_acc;
        logic        lsu_acc;

        // Reset: readies held low even with a request pending.
        i_rst = 1'b1;
        i_ifu_req_valid = 1'b1;
        tick();
        tick();
        check("rst_ifu_ready", o_ifu_req_ready, 1'b0);
        i_ifu_req_valid = 1'b0;
        i_rst = 1'b0;
        #1;
        check("rst_lsu_ready", o_lsu_req_ready, 1'b0);
        check("rst_ifu_rsp", o_ifu_rsp_valid, 1'b0);
        check("rst_lsu_rsp", o_lsu_rsp_valid, 1'b0);
        check("rst_mem_valid", o_mem_req_valid, 1'b0);
        check("rst_mem_addr", o_mem_addr, 64'h0);
        check("rst_mem_wen", o_mem_wen, 1'b0);
        check("rst_mem_wdata", o_mem_wdata, 64'h0);
        check("rst_mem_wmask", o_mem_wmask, 8'h0);
        check("rst_busy", o_busy, 1'b0);

        // IFU read, memory ready at once, response one cycle later.
        snap_l = lsu_pulses;
        i_ifu_req_valid = 1'b1;
        i_ifu_addr      = 64'h8000_0000;
        i_mem_req_ready = 1'b1;
        #1;
        check("t1_ifu_ready", o_ifu_req_ready, 1'b1);
        check("t1_lsu_ready", o_lsu_req_ready, 1'b0);
        tick();
        i_ifu_req_valid = 1'b0;
        #1;
        check("t1_mem_valid", o_mem_req_valid, 1'b1);
        check("t1_mem_addr", o_mem_addr, 64'h8000_0000);
        check("t1_mem_wen", o_mem_wen, 1'b0);
        check("t1_ifu_ready_busy", o_ifu_req_ready, 1'b0);
        tick();
        i_mem_req_ready = 1'b0;
        i_mem_rsp_valid = 1'b1;
        i_mem_rdata     = 64'h0000_0013;
        #1;
        check("t1_ifu_rsp", o_ifu_rsp_valid, 1'b1);
        check("t1_ifu_rdata", o_ifu_rdata, 64'h13);
        check("t1_lsu_rsp", o_lsu_rsp_valid, 1'b0);
        check("t1_lsu_rdata", o_lsu_rdata, 64'h0);
        tick();
        i_mem_rsp_valid = 1'b0;
        i_mem_rdata     = '0;
        #1;
        check("t1_idle", o_busy, 1'b0);
        check("t1_lsu_pulses", lsu_pulses - snap_l, 0);

        // LSU store with ready withheld for three cycles.
        snap_l = lsu_pulses;
        i_lsu_req_valid = 1'b1;
        i_lsu_addr      = 64'h8000_0100;
        i_lsu_wen       = 1'b1;
        i_lsu_wdata     = 64'hDEAD_BEEF;
        i_lsu_wmask     = 8'h0F;
        #1;
        check("t2_lsu_ready", o_lsu_req_ready, 1'b1);
        check("t2_ifu_ready", o_ifu_req_ready, 1'b0);
        tick();
        i_lsu_req_valid = 1'b0;
        i_lsu_addr      = '0;
        i_lsu_wen       = 1'b0;
        i_lsu_wdata     = '1;
        i_lsu_wmask     = '0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check("t2_hold_valid", o_mem_req_valid, 1'b1);
            check("t2_hold_addr", o_mem_addr, 64'h8000_0100);
            check("t2_hold_wen", o_mem_wen, 1'b1);
            check("t2_hold_wdata", o_mem_wdata, 64'hDEAD_BEEF);
            check("t2_hold_wmask", o_mem_wmask, 8'h0F);
            tick();
        end
        i_mem_req_ready = 1'b1;
        #1;
        check("t2_valid_at_ready", o_mem_req_valid, 1'b1);
        tick();
        i_mem_req_ready = 1'b0;
        #1;
        check("t2_wait_rsp", o_lsu_rsp_valid, 1'b0);
        check("t2_busy", o_busy, 1'b1);
        i_mem_rsp_valid = 1'b1;
        i_mem_rdata     = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        check("t2_lsu_rsp", o_lsu_rsp_valid, 1'b1);
        check("t2_store_rdata", o_lsu_rdata, 64'h0);
        check("t2_ifu_rsp", o_ifu_rsp_valid, 1'b0);
        tick();
        i_mem_rsp_valid = 1'b0;
        i_mem_rdata     = '0;
        #1;
        check("t2_idle", o_busy, 1'b0);
        tick();
        check("t2_lsu_pulses", lsu_pulses - snap_l, 1);

        // Both requesting continuously: four LSU grants, then IFU, then LSU.
        m_phase = 0;
        rdly_max = 0;
        sdly_max = 0;
        i_lsu_req_valid = 1'b1;
        i_lsu_addr      = 64'h8000_0200;
        i_lsu_wen       = 1'b0;
        i_ifu_req_valid = 1'b1;
        i_ifu_addr      = 64'h8000_0004;
        order = '0;
        ng = 0;
        #1;
        for (int c = 0; c < 80 && ng < 6; c++) begin
            if (o_lsu_req_ready) begin
                order[ng] = 1'b1;
                ng++;
            end else if (o_ifu_req_ready) begin
                order[ng] = 1'b0;
                ng++;
            end
            tick();
            mem_cycle();
            #1;
        end
        i_lsu_req_valid = 1'b0;
        i_ifu_req_valid = 1'b0;
        check("t3_grant_count", ng, 6);
        exp_order = 6'b10_1111;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("t3_grant%0d_is_lsu", i), order[i], exp_order[i]);
        end
        for (int c = 0; c < 40 && (o_busy || m_phase != 0); c++) begin
            tick();
            mem_cycle();
            #1;
        end
        check("t3_drained", o_busy, 1'b0);

        // Reset while in RSP, then a stray response.
        i_mem_req_ready = 1'b0;
        i_mem_rsp_valid = 1'b0;
        i_ifu_req_valid = 1'b1;
        i_ifu_addr      = 64'h8000_0010;
        tick();
        i_ifu_req_valid = 1'b0;
        i_mem_req_ready = 1'b1;
        tick();
        i_mem_req_ready = 1'b0;
        #1;
        check("t4_in_rsp", o_busy, 1'b1);
        snap_i = ifu_pulses;
        snap_l = lsu_pulses;
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        #1;
        check("t4_busy_after_rst", o_busy, 1'b0);
        check("t4_mem_valid_after_rst", o_mem_req_valid, 1'b0);
        i_mem_rsp_valid = 1'b1;
        i_mem_rdata     = 64'h55;
        #1;
        check("t4_stray_ifu", o_ifu_rsp_valid, 1'b0);
        check("t4_stray_lsu", o_lsu_rsp_valid, 1'b0);
        tick();
        i_mem_rsp_valid = 1'b0;
        i_mem_rdata     = '0;
        tick();
        check("t4_pulses", (ifu_pulses - snap_i) + (lsu_pulses - snap_l), 0);

        // Stray response in IDLE, then a normal IFU fetch.
        i_mem_rsp_valid = 1'b1;
        i_mem_rdata     = 64'hBAD;
        #1;
        check("t5_stray_ifu", o_ifu_rsp_valid, 1'b0);
        check("t5_stray_lsu", o_lsu_rsp_valid, 1'b0);
        tick();
        i_mem_rsp_valid = 1'b0;
        i_mem_rdata     = '0;
        #1;
        check("t5_still_idle", o_busy, 1'b0);
        i_ifu_req_valid = 1'b1;
        i_ifu_addr      = 64'h8000_0008;
        i_mem_req_ready = 1'b1;
        #1;
        check("t5_ifu_ready", o_ifu_req_ready, 1'b1);
        tick();
        i_ifu_req_valid = 1'b0;
        tick();
        i_mem_req_ready = 1'b0;
        i_mem_rsp_valid = 1'b1;
        i_mem_rdata     = 64'h0000_0297;
        #1;
        check("t5_ifu_rsp", o_ifu_rsp_valid, 1'b1);
        check("t5_ifu_rdata", o_ifu_rdata, 64'h297);
        tick();
        i_mem_rsp_valid = 1'b0;
        i_mem_rdata     = '0;
        #1;

        // Random traffic against the scoreboard.
        m_phase     = 0;
        rdly_max    = 5;
        sdly_max    = 5;
        issued      = 0;
        accepted    = 0;
        responded   = 0;
        cyc         = 0;
        exp_pending = 1'b0;
        exp_own     = 1'b0;
        exp_data    = '0;
        ifu_acc     = 1'b0;
        lsu_acc     = 1'b0;
        while (responded < NREQ && cyc < 40000) begin
            tick();
            cyc++;
            mem_cycle();
            if (ifu_acc) i_ifu_req_valid = 1'b0;
            if (lsu_acc) i_lsu_req_valid = 1'b0;
            if (!i_ifu_req_valid && issued < NREQ && $urandom_range(1, 0) == 1) begin
                i_ifu_req_valid = 1'b1;
                i_ifu_addr      = {$urandom, $urandom};
                issued++;
            end
            if (!i_lsu_req_valid && issued < NREQ && $urandom_range(1, 0) == 1) begin
                i_lsu_req_valid = 1'b1;
                i_lsu_addr      = {$urandom, $urandom};
                i_lsu_wen       = 1'($urandom_range(1, 0));
                i_lsu_wdata     = {$urandom, $urandom};
                i_lsu_wmask     = 8'($urandom);
                issued++;
            end
            #1;
            ifu_acc = o_ifu_req_ready;
            lsu_acc = o_lsu_req_ready;
            if (o_ifu_rsp_valid || o_lsu_rsp_valid) begin
                responded++;
                check("rand_rsp_expected", exp_pending, 1'b1);
                check("rand_rsp_owner_lsu", o_lsu_rsp_valid, exp_own);
                check("rand_rsp_data", exp_own ? o_lsu_rdata : o_ifu_rdata, exp_data);
                exp_pending = 1'b0;
            end
            if (o_ifu_req_ready || o_lsu_req_ready) begin
                accepted++;
                exp_pending = 1'b1;
                exp_own     = o_lsu_req_ready;
                if (o_lsu_req_ready) exp_data = i_lsu_wen ? 64'h0 : mem_val(i_lsu_addr);
                else                 exp_data = mem_val(i_ifu_addr);
            end
        end
        check("rand_accepted", accepted, NREQ);
        check("rand_responded", responded, NREQ);
        check("rand_none_pending", exp_pending, 1'b0);
        check("never_two_readys", both_ready_seen, 1'b0);
        check("no_ready_when_busy", ready_busy_seen, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
